path_sequencer: RTL

- Downstream consumer of the path-planner CPU stage.
- Takes the packed 70-bit node path plus its one-cycle load flag and unpacks it into a sequence of single node-to-node moves. Each move is handed to the line-following motion block and held until that block reports arrival.
- Pulses new_path back to the planner once the whole path has been traversed.

---
 rtl/path_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/path_sequencer.sv
// path_sequencer: unpacks a packed 14-slot node path into single node-to-node
// moves, holds each move until the motion block acknowledges arrival, and
// pulses done/new_path once the whole path has been walked.
module path_sequencer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SLOTS          = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5*SLOTS-1:0]   path_in,
  input  logic                 load,
  input  logic                 node_reached,
  output logic                 move_valid,
  output logic [4:0]           cur_node,
  output logic [4:0]           next_node,
  output logic                 busy,
  output logic                 done,
  output logic                 new_path,
  output logic                 timeout_err,
  output logic [3:0]           step_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_TOP    = 4'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [5*SLOTS-1:0] path_reg, path_next;
  logic [3:0]         idx_reg, idx_next;
  logic               pad_reg, pad_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic               move_valid_reg, move_valid_next;
  logic [4:0]         cur_node_reg, cur_node_next;
  logic [4:0]         next_node_reg, next_node_next;
  logic [3:0]         step_reg, step_next;
  logic               timeout_reg, timeout_next;

  // Slot view of the path register; indices beyond the path read as padding.
  logic [4:0] slot_arr [16];
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      if (gi < SLOTS) begin : g_real
        assign slot_arr[gi] = path_reg[5*gi +: 5];
      end else begin : g_pad
        assign slot_arr[gi] = 5'd0;
      end
    end
  endgenerate

  logic [4:0] slot_cur;
  assign slot_cur = slot_arr[idx_reg];

  // State and datapath registers; rst returns everything to the idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      path_reg       <= '0;
      idx_reg        <= IDX_TOP;
      pad_reg        <= 1'b1;
      timer_reg      <= '0;
      move_valid_reg <= 1'b0;
      cur_node_reg   <= 5'd0;
      next_node_reg  <= 5'd0;
      step_reg       <= 4'd0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      path_reg       <= path_next;
      idx_reg        <= idx_next;
      pad_reg        <= pad_next;
      timer_reg      <= timer_next;
      move_valid_reg <= move_valid_next;
      cur_node_reg   <= cur_node_next;
      next_node_reg  <= next_node_next;
      step_reg       <= step_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Next-state logic: one slot examined per SCAN cycle, one move held per WAIT.
  always_comb begin
    state_next      = state_reg;
    path_next       = path_reg;
    idx_next        = idx_reg;
    pad_next        = pad_reg;
    timer_next      = timer_reg;
    move_valid_next = move_valid_reg;
    cur_node_next   = cur_node_reg;
    next_node_next  = next_node_reg;
    step_next       = step_reg;
    timeout_next    = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (load) begin
          path_next    = path_in;
          idx_next     = IDX_TOP;
          pad_next     = 1'b1;
          step_next    = 4'd0;
          timeout_next = 1'b0;
          state_next   = SCAN;
        end
      end

      SCAN: begin
        // Leading zeros are padding; once a real slot is seen, zero is node 0.
        if (!(pad_reg && slot_cur == 5'd0)) begin
          pad_next = 1'b0;
        end
        if ((pad_reg && slot_cur == 5'd0) || slot_cur == cur_node_reg) begin
          if (idx_reg == 4'd0) state_next = DONE;
          else                 idx_next   = idx_reg - 4'd1;
        end else begin
          next_node_next  = slot_cur;
          move_valid_next = 1'b1;
          timer_next      = '0;
          state_next      = WAIT;
        end
      end

      WAIT: begin
        // An acknowledge in the expiry cycle still counts as arrival.
        if (node_reached) begin
          cur_node_next   = next_node_reg;
          move_valid_next = 1'b0;
          if (step_reg != 4'd15) step_next = step_reg + 4'd1;
          if (idx_reg == 4'd0) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg - 4'd1;
            state_next = SCAN;
          end
        end else if (timer_reg == TIMER_LAST) begin
          move_valid_next = 1'b0;
          timeout_next    = 1'b1;
          state_next      = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign move_valid  = move_valid_reg;
  assign cur_node    = cur_node_reg;
  assign next_node   = next_node_reg;
  assign step_count  = step_reg;
  assign timeout_err = timeout_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign new_path    = (state_reg == DONE);

endmodule
